// File: rtl/logic_pipe_pkg.sv
// Shared definitions for the logic_pipe bitwise logic unit: operation
// encoding and the single-bit evaluation function.
package logic_pipe_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  // All operations are bitwise, so evaluating one bit position at a time
  // keeps the function independent of the operand width.
  function automatic logic logic_eval(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_ANDN:  r = a & ~b;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One elastic register slice of logic_pipe: holds a valid flag and a data
// word, loads a new beat whenever it is empty or its content is leaving.
module logic_pipe_stage
  import logic_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  logic             valid_d;
  logic [WIDTH-1:0] data_d;
  logic             load_en;

  // Next-state: take the upstream beat when this slot is free or draining;
  // data holds when nothing new arrives so an emptied slot keeps its word.
  always_comb begin
    load_en = !valid_q | (valid_q & down_ready);
    valid_d = valid_q;
    data_d  = data_q;
    if (load_en) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  // Slice registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: parametrised, elastic, pipelined bitwise logic unit with a
// valid/ready handshake. Optional accepted-result counter out_count is
// built only when the macro LOGIC_PIPE_CNT_EN is defined.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef LOGIC_PIPE_CNT_EN
  ,
  output logic [31:0]      out_count
`endif
);

  logic [WIDTH-1:0]  res;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] down_rdy;
  logic              chain;

  // Combinational result from the operands at the input port.
  always_comb begin
    res = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      res[i] = logic_eval(op_e'(op), a[i], b[i]);
    end
  end

  // Readiness is derived from the registered valid flags instead of a
  // stage-to-stage ready chain: stage k may move on when the output is
  // taken or any later stage has a hole (!v[k] | adv[k] collapses to this).
  always_comb begin
    chain    = out_ready;
    down_rdy = '0;
    for (int unsigned i = STAGES; i > 0; i--) begin
      down_rdy[i-1] = chain;
      chain         = chain | ~v[i-1];
    end
  end

  assign in_ready = chain;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = res;
    end else begin : g_body
      assign up_valid = v[k-1];
      assign up_data  = d[k-1];
    end

    logic_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clock      (clock),
      .reset      (reset),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .down_ready (down_rdy[k]),
      .valid_q    (v[k]),
      .data_q     (d[k])
    );
  end

  assign out_valid = v[STAGES-1];
  assign y         = d[STAGES-1];

`ifdef LOGIC_PIPE_CNT_EN
  logic [31:0] count_q;
  logic [31:0] count_d;

  // Count every result handed to the consumer; wraps naturally.
  always_comb begin
    count_d = count_q;
    if (out_valid & out_ready) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Self-checking bench for logic_pipe. Four instances share one stimulus
// stream (8-bit with 1/2/3 stages, 13-bit with 4 stages); each has its own
// scoreboard queue fed on acceptance and drained on emission.
module tb_logic_pipe;

  logic        clock;
  logic        reset_r;
  logic        in_valid_r;
  logic        out_ready_r;
  logic [2:0]  op_r;
  logic [12:0] a_r;
  logic [12:0] b_r;

  logic [3:0]  rdy_v;
  logic [3:0]  ov_v;
  logic [7:0]  y1, y2, y3;
  logic [12:0] y13;
  logic [12:0] y_v [4];
`ifdef LOGIC_PIPE_CNT_EN
  logic [31:0] cnt_v [4];
`endif

  logic [12:0] sb [4][$];
  int          accepts [4];
  int          emits   [4];
  int          pass_cnt;
  int          total_cnt;

  assign y_v[0] = {5'b0, y1};
  assign y_v[1] = {5'b0, y2};
  assign y_v[2] = {5'b0, y3};
  assign y_v[3] = y13;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic_pipe #(.WIDTH(8), .STAGES(1)) u1 (
    .clock(clock), .reset(reset_r), .in_valid(in_valid_r), .in_ready(rdy_v[0]),
    .op(op_r), .a(a_r[7:0]), .b(b_r[7:0]), .out_valid(ov_v[0]),
    .out_ready(out_ready_r), .y(y1)
`ifdef LOGIC_PIPE_CNT_EN
    , .out_count(cnt_v[0])
`endif
  );

  logic_pipe #(.WIDTH(8), .STAGES(2)) u2 (
    .clock(clock), .reset(reset_r), .in_valid(in_valid_r), .in_ready(rdy_v[1]),
    .op(op_r), .a(a_r[7:0]), .b(b_r[7:0]), .out_valid(ov_v[1]),
    .out_ready(out_ready_r), .y(y2)
`ifdef LOGIC_PIPE_CNT_EN
    , .out_count(cnt_v[1])
`endif
  );

  logic_pipe #(.WIDTH(8), .STAGES(3)) u3 (
    .clock(clock), .reset(reset_r), .in_valid(in_valid_r), .in_ready(rdy_v[2]),
    .op(op_r), .a(a_r[7:0]), .b(b_r[7:0]), .out_valid(ov_v[2]),
    .out_ready(out_ready_r), .y(y3)
`ifdef LOGIC_PIPE_CNT_EN
    , .out_count(cnt_v[2])
`endif
  );

  logic_pipe #(.WIDTH(13), .STAGES(4)) u13 (
    .clock(clock), .reset(reset_r), .in_valid(in_valid_r), .in_ready(rdy_v[3]),
    .op(op_r), .a(a_r), .b(b_r), .out_valid(ov_v[3]),
    .out_ready(out_ready_r), .y(y13)
`ifdef LOGIC_PIPE_CNT_EN
    , .out_count(cnt_v[3])
`endif
  );

  // Independent reference for the eight operations.
  function automatic logic [12:0] model(input logic [2:0] o, input logic [12:0] x,
                                        input logic [12:0] z, input int idx);
    logic [12:0] r;
    case (o)
      3'd0: r = x & z;
      3'd1: r = x | z;
      3'd2: r = x ^ z;
      3'd3: r = ~(x & z);
      3'd4: r = ~(x | z);
      3'd5: r = ~(x ^ z);
      3'd6: r = x & ~z;
      default: r = x;
    endcase
    if (idx < 3) r = r & 13'h00FF;
    return r;
  endfunction

  // One clock: observe handshakes before the edge, update scoreboards,
  // then return 1 time unit after the rising edge.
  task automatic cycle();
    logic [12:0] exp;
    @(negedge clock);
    if (reset_r) begin
      for (int i = 0; i < 4; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ov_v[i] && out_ready_r) begin
          total_cnt++;
          emits[i]++;
          if (sb[i].size() == 0) begin
            $display("FAIL sb_unexpected[%0d]: got y=%h, required no output", i, y_v[i]);
          end else begin
            exp = sb[i].pop_front();
            if (y_v[i] !== exp)
              $display("FAIL sb_data[%0d]: got y=%h, required %h", i, y_v[i], exp);
            else
              pass_cnt++;
          end
        end
        if (in_valid_r && rdy_v[i]) begin
          sb[i].push_back(model(op_r, a_r, b_r, i));
          accepts[i]++;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_r = 1'b1; in_valid_r = 1'b1; out_ready_r = 1'b1;
    cycle(); cycle();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (ov_v[i] !== 1'b0) $display("FAIL reset_ov[%0d]: got %b, required 0", i, ov_v[i]);
      else pass_cnt++;
      total_cnt++;
      if (y_v[i] !== 13'h0) $display("FAIL reset_y[%0d]: got %h, required 0", i, y_v[i]);
      else pass_cnt++;
      total_cnt++;
      if (rdy_v[i] !== 1'b1) $display("FAIL reset_rdy[%0d]: got %b, required 1", i, rdy_v[i]);
      else pass_cnt++;
    end
    reset_r = 1'b0; in_valid_r = 1'b0;
  endtask

  task automatic test_idle();
    int a0, e0;
    in_valid_r = 1'b0; out_ready_r = 1'b1;
    a0 = accepts[3]; e0 = emits[3];
    for (int n = 0; n < 10; n++) begin
      cycle();
      total_cnt++;
      if (ov_v !== 4'b0) $display("FAIL idle_ov: got %b, required 0000", ov_v);
      else pass_cnt++;
    end
    total_cnt++;
    if (accepts[3] != a0 || emits[3] != e0)
      $display("FAIL idle_handshake: got acc=%0d emit=%0d, required %0d/%0d",
               accepts[3], emits[3], a0, e0);
    else pass_cnt++;
  endtask

  task automatic test_nand_s1();
    out_ready_r = 1'b1; in_valid_r = 1'b1;
    op_r = 3'd3; a_r = 13'h0F; b_r = 13'h0F;
    total_cnt++;
    if (rdy_v[0] !== 1'b1) $display("FAIL nand_rdy: got %b, required 1", rdy_v[0]);
    else pass_cnt++;
    cycle();
    in_valid_r = 1'b0;
    total_cnt++;
    if (ov_v[0] !== 1'b1 || y1 !== 8'hF0)
      $display("FAIL nand_s1: got v=%b y=%h, required v=1 y=f0", ov_v[0], y1);
    else pass_cnt++;
    total_cnt++;
    if (ov_v[1] !== 1'b0) $display("FAIL nand_s2_early: got v=%b, required 0", ov_v[1]);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (ov_v[1] !== 1'b1 || y2 !== 8'hF0)
      $display("FAIL nand_s2: got v=%b y=%h, required v=1 y=f0", ov_v[1], y2);
    else pass_cnt++;
    for (int n = 0; n < 4; n++) cycle();
  endtask

  task automatic test_op_sweep();
    logic [7:0] tbl [8];
    tbl[0] = 8'h48; tbl[1] = 8'hDE; tbl[2] = 8'h96; tbl[3] = 8'hB7;
    tbl[4] = 8'h21; tbl[5] = 8'h69; tbl[6] = 8'h82; tbl[7] = 8'hCA;
    out_ready_r = 1'b1; a_r = 13'h0CA; b_r = 13'h05C;
    for (int i = 0; i < 10; i++) begin
      in_valid_r = (i < 8);
      op_r = 3'(i);
      total_cnt++;
      if (i < 8 && rdy_v[1] !== 1'b1) $display("FAIL sweep_rdy[%0d]: got 0, required 1", i);
      else pass_cnt++;
      cycle();
      if (i >= 1 && i <= 8) begin
        total_cnt++;
        if (ov_v[1] !== 1'b1 || y2 !== tbl[i-1])
          $display("FAIL sweep_y[%0d]: got v=%b y=%h, required v=1 y=%h", i-1, ov_v[1], y2, tbl[i-1]);
        else pass_cnt++;
      end
    end
    in_valid_r = 1'b0;
    for (int n = 0; n < 4; n++) cycle();
  endtask

  task automatic test_backpressure();
    int acc0, em0, acc, em;
    in_valid_r = 1'b0; out_ready_r = 1'b1;
    for (int n = 0; n < 5; n++) cycle();
    acc0 = accepts[2]; em0 = emits[2];
    out_ready_r = 1'b0; op_r = 3'd7; b_r = 13'h0;
    for (int n = 0; n < 10; n++) begin
      acc = accepts[2] - acc0;
      in_valid_r = (acc < 5);
      a_r = 13'(8'h10 + acc);
      cycle();
    end
    total_cnt++;
    if (accepts[2] - acc0 != 3)
      $display("FAIL bp_accepted: got %0d, required 3", accepts[2] - acc0);
    else pass_cnt++;
    total_cnt++;
    if (rdy_v[2] !== 1'b0) $display("FAIL bp_rdy: got %b, required 0", rdy_v[2]);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (ov_v[2] !== 1'b1 || y3 !== 8'h10)
      $display("FAIL bp_hold: got v=%b y=%h, required v=1 y=10", ov_v[2], y3);
    else pass_cnt++;
    out_ready_r = 1'b1;
    for (int n = 0; n < 20; n++) begin
      acc = accepts[2] - acc0;
      em  = emits[2] - em0;
      if (em >= 5) break;
      in_valid_r = (acc < 5);
      a_r = 13'(8'h10 + acc);
      cycle();
    end
    in_valid_r = 1'b0;
    total_cnt++;
    if (emits[2] - em0 != 5 || accepts[2] - acc0 != 5)
      $display("FAIL bp_drain: got emit=%0d acc=%0d, required 5/5",
               emits[2] - em0, accepts[2] - acc0);
    else pass_cnt++;
    for (int n = 0; n < 6; n++) cycle();
  endtask

  task automatic test_reset_flight();
    int em0;
    out_ready_r = 1'b1; in_valid_r = 1'b1; op_r = 3'd2;
    a_r = 13'h0A5; b_r = 13'h0FF; cycle();
    a_r = 13'h05A; cycle();
    reset_r = 1'b1;
    cycle();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (ov_v[i] !== 1'b0 || y_v[i] !== 13'h0 || rdy_v[i] !== 1'b1)
        $display("FAIL flight_reset[%0d]: got v=%b y=%h r=%b, required v=0 y=0 r=1",
                 i, ov_v[i], y_v[i], rdy_v[i]);
      else pass_cnt++;
    end
    reset_r = 1'b0; in_valid_r = 1'b0;
    em0 = emits[2];
    for (int n = 0; n < 6; n++) cycle();
    total_cnt++;
    if (emits[2] != em0) $display("FAIL flight_lost: got %0d emits, required 0", emits[2] - em0);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int acc0 [4];
    int em0 [4];
    reset_r = 1'b1; in_valid_r = 1'b0;
    cycle();
    reset_r = 1'b0;
    for (int i = 0; i < 4; i++) begin acc0[i] = accepts[i]; em0[i] = emits[i]; end
    for (int n = 0; n < 10000; n++) begin
      if (accepts[3] - acc0[3] >= 1000 && emits[3] - em0[3] >= 1000) break;
      in_valid_r  = (accepts[3] - acc0[3] < 1000);
      a_r         = 13'($urandom);
      b_r         = 13'($urandom);
      op_r        = 3'($urandom_range(0, 7));
      out_ready_r = 1'($urandom_range(0, 1));
      cycle();
    end
    total_cnt++;
    if (accepts[3] - acc0[3] != 1000 || emits[3] - em0[3] != 1000)
      $display("FAIL rand_count: got acc=%0d emit=%0d, required 1000/1000",
               accepts[3] - acc0[3], emits[3] - em0[3]);
    else pass_cnt++;
    in_valid_r = 1'b0; out_ready_r = 1'b1;
    for (int n = 0; n < 8; n++) cycle();
`ifdef LOGIC_PIPE_CNT_EN
    total_cnt++;
    if (cnt_v[3] !== 32'd1000) $display("FAIL out_count13: got %0d, required 1000", cnt_v[3]);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (cnt_v[i] !== 32'(emits[i] - em0[i]))
        $display("FAIL out_count[%0d]: got %0d, required %0d", i, cnt_v[i], emits[i] - em0[i]);
      else pass_cnt++;
    end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt = 0; total_cnt = 0;
    for (int i = 0; i < 4; i++) begin accepts[i] = 0; emits[i] = 0; end
    reset_r = 1'b1; in_valid_r = 1'b0; out_ready_r = 1'b1;
    op_r = 3'd0; a_r = 13'h0; b_r = 13'h0;
    test_reset();
    test_idle();
    test_nand_s1();
    test_op_sweep();
    test_backpressure();
    test_reset_flight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
